hsv_core_branch_resolve: RTL and testbench

Parametrised branch/jump resolution stage for the ScaleCore-V execute cluster. It resolves the final PC from the taken flag and target, then flags mispredicts and misaligned targets. Results travel through a configurable-depth pipeline to commit. The block also emits a one-shot predictor-update pulse per resolved branch and keeps saturating branch and mispredict performance counters.

---
 rtl/hsv_core_branch_resolve.sv | 150 +++++++++++++++
 tb/tb_hsv_core_branch_resolve.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_core_branch_resolve.sv
// Branch/jump resolution stage: resolves the next PC, flags mispredicts and
// misaligned targets, carries the result through PIPE_STAGES registers to
// commit, pulses a one-shot predictor update and keeps saturating counters.
module hsv_core_branch_resolve #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 1,
  parameter int ALIGN_BYTES = 4,
  parameter int COMMON_W    = 64,
  parameter int CNT_W       = 32
) (
  input  logic                clk_core,
  input  logic                rst_core,
  input  logic                stall,
  input  logic                flush_req,
  input  logic                valid_i,
  input  logic [COMMON_W-1:0] in_common,
  input  logic [XLEN-1:0]     in_pc_increment,
  input  logic [XLEN-1:0]     in_predicted,
  input  logic                in_taken,
  input  logic [XLEN-1:0]     in_target,
  input  logic                in_link,
  input  logic                in_is_cond,
  output logic                valid_o,
  output logic [COMMON_W-1:0] out_common,
  output logic                out_jump,
  output logic                out_trap,
  output logic [XLEN-1:0]     out_result,
  output logic [XLEN-1:0]     out_next_pc,
  output logic                out_writeback,
  output logic                upd_valid,
  output logic [XLEN-1:0]     upd_pc,
  output logic                upd_taken,
  output logic [XLEN-1:0]     upd_target,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    branch_cnt,
  output logic [CNT_W-1:0]    mispredict_cnt
);

  // Low address bits that must be zero in a taken target (ALIGN_BYTES=1 never traps).
  localparam int AW = (ALIGN_BYTES > 1) ? $clog2(ALIGN_BYTES) : 1;

  typedef struct packed {
    logic [COMMON_W-1:0] common;
    logic [XLEN-1:0]     pc_inc;
    logic [XLEN-1:0]     next_pc;
    logic [XLEN-1:0]     target;
    logic                taken;
    logic                jump;
    logic                trap;
    logic                writeback;
  } ent_t;

  // Direction class is not needed: jumps and branches resolve identically here.
  logic unused_is_cond;
  assign unused_is_cond = in_is_cond;

  ent_t             ent_s0;
  logic [XLEN-1:0]  final_pc;
  logic             misaligned;

  ent_t                   ent_q [PIPE_STAGES:1];
  ent_t                   ent_d [PIPE_STAGES:1];
  logic [PIPE_STAGES:1]   vld_pipe_q, vld_pipe_d;
  logic                   fresh_q, fresh_d;
  logic [CNT_W-1:0]       branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]       mispredict_cnt_q, mispredict_cnt_d;
  logic                   retire;

  // Stage 0: resolve final PC, mispredict and alignment trap from the inputs.
  always_comb begin
    final_pc          = in_taken ? in_target : in_pc_increment;
    misaligned        = (ALIGN_BYTES > 1) && (in_target[AW-1:0] != '0);
    ent_s0            = '0;
    ent_s0.common     = in_common;
    ent_s0.pc_inc     = in_pc_increment;
    ent_s0.next_pc    = final_pc;
    ent_s0.target     = in_target;
    ent_s0.taken      = in_taken;
    ent_s0.jump       = (final_pc != in_predicted);
    ent_s0.trap       = in_taken & misaligned;
    ent_s0.writeback  = in_link;
  end

  // Pipeline advance: shift when not stalled; flush kills every valid bit.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    ent_d      = ent_q;
    if (!stall) begin
      vld_pipe_d[1] = valid_i;
      ent_d[1]      = ent_s0;
      for (int i = 2; i <= PIPE_STAGES; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        ent_d[i]      = ent_q[i-1];
      end
    end
    if (flush_req) vld_pipe_d = '0;
    // A new entry lands in the output stage only on an unstalled, unflushed
    // edge; any other edge means the current entry has been presented once.
    fresh_d = ~stall & vld_pipe_d[PIPE_STAGES];
  end

  // Saturating counters; clear beats a simultaneous retire.
  always_comb begin
    retire           = vld_pipe_q[PIPE_STAGES] & ~stall & ~flush_req;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (cnt_clr) begin
      branch_cnt_d     = '0;
      mispredict_cnt_d = '0;
    end else if (retire) begin
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (ent_q[PIPE_STAGES].jump && !ent_q[PIPE_STAGES].trap &&
          mispredict_cnt_q != '1)
        mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset of valid, payload and counters.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      vld_pipe_q       <= '0;
      fresh_q          <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      for (int i = 1; i <= PIPE_STAGES; i++) ent_q[i] <= '0;
    end else begin
      vld_pipe_q       <= vld_pipe_d;
      fresh_q          <= fresh_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      for (int i = 1; i <= PIPE_STAGES; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign valid_o        = vld_pipe_q[PIPE_STAGES];
  assign out_common     = ent_q[PIPE_STAGES].common;
  assign out_jump       = ent_q[PIPE_STAGES].jump;
  assign out_trap       = ent_q[PIPE_STAGES].trap;
  assign out_result     = ent_q[PIPE_STAGES].pc_inc;
  assign out_next_pc    = ent_q[PIPE_STAGES].next_pc;
  assign out_writeback  = ent_q[PIPE_STAGES].writeback;
  // Predictor is indexed by the fall-through PC of the resolved entry.
  assign upd_valid      = valid_o & fresh_q & ~out_trap;
  assign upd_pc         = ent_q[PIPE_STAGES].pc_inc;
  assign upd_taken      = ent_q[PIPE_STAGES].taken;
  assign upd_target     = ent_q[PIPE_STAGES].target;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_hsv_core_branch_resolve.sv
// Directed bench: three instances share stimulus (2-stage/align4,
// 2-stage/align2, 1-stage/4-bit counters) and are checked per scenario.
module tb_hsv_core_branch_resolve;

  logic        clk = 1'b0;
  logic        rst, stall, flush, vld_in, taken, link, is_cond, clr;
  logic [63:0] common;
  logic [31:0] pcinc, pred, target;

  logic        a_vo, a_jmp, a_trap, a_wb, a_uv, a_ut;
  logic [63:0] a_com;
  logic [31:0] a_res, a_npc, a_upc, a_utgt, a_bc, a_mc;
  logic        c_vo, c_jmp, c_trap, c_wb, c_uv, c_ut;
  logic [63:0] c_com;
  logic [31:0] c_res, c_npc, c_upc, c_utgt, c_bc, c_mc;
  logic        s_vo, s_jmp, s_trap, s_wb, s_uv, s_ut;
  logic [63:0] s_com;
  logic [31:0] s_res, s_npc, s_upc, s_utgt;
  logic [3:0]  s_bc, s_mc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hsv_core_branch_resolve #(.XLEN(32), .PIPE_STAGES(2), .ALIGN_BYTES(4), .COMMON_W(64), .CNT_W(32)) dut_a (
    .clk_core(clk), .rst_core(rst), .stall(stall), .flush_req(flush), .valid_i(vld_in),
    .in_common(common), .in_pc_increment(pcinc), .in_predicted(pred), .in_taken(taken),
    .in_target(target), .in_link(link), .in_is_cond(is_cond), .valid_o(a_vo),
    .out_common(a_com), .out_jump(a_jmp), .out_trap(a_trap), .out_result(a_res),
    .out_next_pc(a_npc), .out_writeback(a_wb), .upd_valid(a_uv), .upd_pc(a_upc),
    .upd_taken(a_ut), .upd_target(a_utgt), .cnt_clr(clr), .branch_cnt(a_bc), .mispredict_cnt(a_mc));

  hsv_core_branch_resolve #(.XLEN(32), .PIPE_STAGES(2), .ALIGN_BYTES(2), .COMMON_W(64), .CNT_W(32)) dut_c (
    .clk_core(clk), .rst_core(rst), .stall(stall), .flush_req(flush), .valid_i(vld_in),
    .in_common(common), .in_pc_increment(pcinc), .in_predicted(pred), .in_taken(taken),
    .in_target(target), .in_link(link), .in_is_cond(is_cond), .valid_o(c_vo),
    .out_common(c_com), .out_jump(c_jmp), .out_trap(c_trap), .out_result(c_res),
    .out_next_pc(c_npc), .out_writeback(c_wb), .upd_valid(c_uv), .upd_pc(c_upc),
    .upd_taken(c_ut), .upd_target(c_utgt), .cnt_clr(clr), .branch_cnt(c_bc), .mispredict_cnt(c_mc));

  hsv_core_branch_resolve #(.XLEN(32), .PIPE_STAGES(1), .ALIGN_BYTES(4), .COMMON_W(64), .CNT_W(4)) dut_s (
    .clk_core(clk), .rst_core(rst), .stall(stall), .flush_req(flush), .valid_i(vld_in),
    .in_common(common), .in_pc_increment(pcinc), .in_predicted(pred), .in_taken(taken),
    .in_target(target), .in_link(link), .in_is_cond(is_cond), .valid_o(s_vo),
    .out_common(s_com), .out_jump(s_jmp), .out_trap(s_trap), .out_result(s_res),
    .out_next_pc(s_npc), .out_writeback(s_wb), .upd_valid(s_uv), .upd_pc(s_upc),
    .upd_taken(s_ut), .upd_target(s_utgt), .cnt_clr(clr), .branch_cnt(s_bc), .mispredict_cnt(s_mc));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic tk, input logic [31:0] tg, input logic [31:0] pr,
                       input logic [31:0] pi, input logic lk, input logic [63:0] cm);
    vld_in = 1'b1; taken = tk; target = tg; pred = pr; pcinc = pi; link = lk; common = cm;
    is_cond = 1'b1;
  endtask

  task automatic idle();
    vld_in = 1'b0; taken = 1'b0; target = '0; pred = '0; pcinc = '0; link = 1'b0; common = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; clr = 1'b0; idle();
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; clr = 1'b0;
    drive(1'b1, 32'h100, 32'h0, 32'h44, 1'b1, 64'hFFFF_0000_FFFF_0000);
    step(); step(); step();
    n_cmp++; if (a_vo !== 1'b0) begin n_bad++; $display("FAIL reset_valid_o got %b want 0", a_vo); end
    n_cmp++; if (a_uv !== 1'b0) begin n_bad++; $display("FAIL reset_upd_valid got %b want 0", a_uv); end
    n_cmp++; if (a_bc !== 32'd0 || a_mc !== 32'd0) begin n_bad++; $display("FAIL reset_counters got %0d/%0d want 0/0", a_bc, a_mc); end
    n_cmp++; if (a_npc !== 32'd0 || a_res !== 32'd0 || a_com !== 64'd0 || a_upc !== 32'd0) begin
      n_bad++; $display("FAIL reset_payload got npc=%h res=%h com=%h upc=%h want 0", a_npc, a_res, a_com, a_upc); end
    n_cmp++; if (s_vo !== 1'b0) begin n_bad++; $display("FAIL reset_valid_o_p1 got %b want 0", s_vo); end
    rst = 1'b0; idle();
  endtask

  task automatic test_taken_correct();
    do_reset();
    drive(1'b1, 32'h100, 32'h100, 32'h44, 1'b1, 64'hDEAD_BEEF_0000_0001);
    step(); idle();
    n_cmp++; if (a_vo !== 1'b0) begin n_bad++; $display("FAIL tc_early_valid got %b want 0", a_vo); end
    n_cmp++; if (s_vo !== 1'b1 || s_npc !== 32'h100) begin n_bad++; $display("FAIL tc_p1_latency got v=%b npc=%h want 1/100", s_vo, s_npc); end
    step();
    n_cmp++; if (a_vo !== 1'b1) begin n_bad++; $display("FAIL tc_valid got %b want 1", a_vo); end
    n_cmp++; if (a_jmp !== 1'b0 || a_trap !== 1'b0) begin n_bad++; $display("FAIL tc_jump_trap got %b/%b want 0/0", a_jmp, a_trap); end
    n_cmp++; if (a_npc !== 32'h100 || a_res !== 32'h44) begin n_bad++; $display("FAIL tc_pc got npc=%h res=%h want 100/44", a_npc, a_res); end
    n_cmp++; if (a_com !== 64'hDEAD_BEEF_0000_0001 || a_wb !== 1'b1) begin n_bad++; $display("FAIL tc_common_wb got %h/%b want deadbeef00000001/1", a_com, a_wb); end
    n_cmp++; if (a_uv !== 1'b1 || a_ut !== 1'b1 || a_utgt !== 32'h100 || a_upc !== 32'h44) begin
      n_bad++; $display("FAIL tc_upd got v=%b t=%b tgt=%h pc=%h want 1/1/100/44", a_uv, a_ut, a_utgt, a_upc); end
    n_cmp++; if (a_bc !== 32'd0) begin n_bad++; $display("FAIL tc_cnt_before_retire got %0d want 0", a_bc); end
    step();
    n_cmp++; if (a_vo !== 1'b0 || a_uv !== 1'b0) begin n_bad++; $display("FAIL tc_drain got v=%b uv=%b want 0/0", a_vo, a_uv); end
    n_cmp++; if (a_bc !== 32'd1 || a_mc !== 32'd0) begin n_bad++; $display("FAIL tc_counters got %0d/%0d want 1/0", a_bc, a_mc); end
  endtask

  task automatic test_not_taken_mispredict();
    do_reset();
    drive(1'b0, 32'h300, 32'h200, 32'h48, 1'b0, 64'h2);
    step(); idle(); step();
    n_cmp++; if (a_npc !== 32'h48 || a_jmp !== 1'b1) begin n_bad++; $display("FAIL nt_resolve got npc=%h jmp=%b want 48/1", a_npc, a_jmp); end
    n_cmp++; if (a_uv !== 1'b1 || a_ut !== 1'b0 || a_wb !== 1'b0) begin n_bad++; $display("FAIL nt_upd got uv=%b ut=%b wb=%b want 1/0/0", a_uv, a_ut, a_wb); end
    step();
    n_cmp++; if (a_bc !== 32'd1 || a_mc !== 32'd1) begin n_bad++; $display("FAIL nt_counters got %0d/%0d want 1/1", a_bc, a_mc); end
  endtask

  task automatic test_misaligned();
    do_reset();
    drive(1'b1, 32'h102, 32'h0, 32'h50, 1'b1, 64'h3);
    step(); idle(); step();
    n_cmp++; if (a_trap !== 1'b1 || a_uv !== 1'b0) begin n_bad++; $display("FAIL mis_trap4 got trap=%b uv=%b want 1/0", a_trap, a_uv); end
    n_cmp++; if (c_trap !== 1'b0 || c_uv !== 1'b1) begin n_bad++; $display("FAIL mis_trap2 got trap=%b uv=%b want 0/1", c_trap, c_uv); end
    step();
    n_cmp++; if (a_bc !== 32'd1 || a_mc !== 32'd0) begin n_bad++; $display("FAIL mis_cnt4 got %0d/%0d want 1/0", a_bc, a_mc); end
    n_cmp++; if (c_bc !== 32'd1 || c_mc !== 32'd1) begin n_bad++; $display("FAIL mis_cnt2 got %0d/%0d want 1/1", c_bc, c_mc); end
  endtask

  task automatic test_stall();
    int pulses;
    int held;
    do_reset();
    drive(1'b1, 32'h100, 32'h100, 32'h44, 1'b0, 64'h4);
    step(); idle(); step();
    pulses = (a_uv === 1'b1) ? 1 : 0;
    held = 0;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (a_uv === 1'b1) pulses++;
      if (a_vo === 1'b1 && a_bc === 32'd0) held++;
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL stall_pulses got %0d want 1", pulses); end
    n_cmp++; if (held !== 5) begin n_bad++; $display("FAIL stall_hold got %0d want 5", held); end
    stall = 1'b0;
    step();
    n_cmp++; if (a_bc !== 32'd1 || a_vo !== 1'b0) begin n_bad++; $display("FAIL stall_release got cnt=%0d v=%b want 1/0", a_bc, a_vo); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 32'h100, 32'h100, 32'h44, 1'b0, 64'h5);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h48, 1'b0, 64'h6);
    step(); idle();
    stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    n_cmp++; if (a_vo !== 1'b0 || a_uv !== 1'b0) begin n_bad++; $display("FAIL flush_kill got v=%b uv=%b want 0/0", a_vo, a_uv); end
    step();
    n_cmp++; if (a_vo !== 1'b0 || a_uv !== 1'b0) begin n_bad++; $display("FAIL flush_second got v=%b uv=%b want 0/0", a_vo, a_uv); end
    n_cmp++; if (a_bc !== 32'd0 || a_mc !== 32'd0) begin n_bad++; $display("FAIL flush_counters got %0d/%0d want 0/0", a_bc, a_mc); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive(1'b1, 32'h100, 32'h0, 32'h44, 1'b0, 64'h7);
    step(); idle();
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++; if (a_vo !== 1'b0 || a_uv !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got v=%b uv=%b want 0/0", a_vo, a_uv); end
    step(); step();
    n_cmp++; if (a_vo !== 1'b0 || a_bc !== 32'd0 || a_mc !== 32'd0) begin
      n_bad++; $display("FAIL midrst_after got v=%b cnt=%0d/%0d want 0/0/0", a_vo, a_bc, a_mc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 32'h1000, 32'h1000, 32'h10, 1'b0, 64'hA0);
    step();
    drive(1'b0, 32'h0, 32'h14, 32'h14, 1'b0, 64'hA1);
    step();
    drive(1'b1, 32'h2000, 32'h24, 32'h24, 1'b0, 64'hA2);
    n_cmp++; if (a_vo !== 1'b1 || a_npc !== 32'h1000 || a_jmp !== 1'b0 || a_uv !== 1'b1) begin
      n_bad++; $display("FAIL b2b_e0 got v=%b npc=%h jmp=%b uv=%b want 1/1000/0/1", a_vo, a_npc, a_jmp, a_uv); end
    step(); idle();
    n_cmp++; if (a_vo !== 1'b1 || a_npc !== 32'h14 || a_jmp !== 1'b0 || a_uv !== 1'b1 || a_com !== 64'hA1) begin
      n_bad++; $display("FAIL b2b_e1 got v=%b npc=%h jmp=%b uv=%b com=%h want 1/14/0/1/a1", a_vo, a_npc, a_jmp, a_uv, a_com); end
    step();
    n_cmp++; if (a_vo !== 1'b1 || a_npc !== 32'h2000 || a_jmp !== 1'b1 || a_uv !== 1'b1) begin
      n_bad++; $display("FAIL b2b_e2 got v=%b npc=%h jmp=%b uv=%b want 1/2000/1/1", a_vo, a_npc, a_jmp, a_uv); end
    step();
    n_cmp++; if (a_vo !== 1'b0 || a_bc !== 32'd3 || a_mc !== 32'd1) begin
      n_bad++; $display("FAIL b2b_counts got v=%b cnt=%0d/%0d want 0/3/1", a_vo, a_bc, a_mc); end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    drive(1'b1, 32'h100, 32'h100, 32'h44, 1'b0, 64'h8);
    for (int i = 0; i < 16; i++) step();
    n_cmp++; if (s_bc !== 4'd15) begin n_bad++; $display("FAIL sat_preload got %0d want 15", s_bc); end
    step();
    n_cmp++; if (s_bc !== 4'd15) begin n_bad++; $display("FAIL sat_16th got %0d want 15", s_bc); end
    step();
    n_cmp++; if (s_bc !== 4'd15 || s_mc !== 4'd0) begin n_bad++; $display("FAIL sat_hold got %0d/%0d want 15/0", s_bc, s_mc); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_cmp++; if (s_bc !== 4'd0) begin n_bad++; $display("FAIL clr_with_retire got %0d want 0", s_bc); end
    step();
    n_cmp++; if (s_bc !== 4'd1) begin n_bad++; $display("FAIL clr_resume got %0d want 1", s_bc); end
    idle();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; clr = 1'b0; is_cond = 1'b0; idle();
    test_reset();
    test_taken_correct();
    test_not_taken_mispredict();
    test_misaligned();
    test_stall();
    test_flush();
    test_reset_midflight();
    test_back_to_back();
    test_saturate_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
